// File: rtl/seg7_scan_decoder.sv
// Rebuilds BCD digits from a multiplexed active-high 7-segment bus and hands out whole frames.
// Define SEG7_HEX_DECODE_EN to accept the A-F patterns as valid digits.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg,
    input  logic [NUM_DIGITS-1:0]   dig,
    input  logic                    frame_ready,
    input  logic                    err_clr,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_dp,
    output logic [NUM_DIGITS-1:0]   frame_blank,
    output logic [NUM_DIGITS-1:0]   frame_inv,
    output logic                    err,
    output logic                    overrun
);
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_t;

    localparam logic [3:0] STABLE_W = 4'(STABLE_CNT);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic [4*NUM_DIGITS-1:0] wk_bcd_q, wk_bcd_d, fbcd_q, fbcd_d;
    logic [NUM_DIGITS-1:0]   wk_dp_q, wk_dp_d, wk_blank_q, wk_blank_d, wk_inv_q, wk_inv_d;
    logic [NUM_DIGITS-1:0]   fdp_q, fdp_d, fblank_q, fblank_d, finv_q, finv_d;
    logic [NUM_DIGITS-1:0]   captured_q, captured_d;
    logic                    fv_q, fv_d, err_q, err_d, ovr_q, ovr_d;

    logic       dig_onehot, same, capture;
    logic [3:0] dec_nib;
    logic       dec_blank, dec_inv;

    // The sample entering the input register is compared with the one already held,
    // so the capture lands on the edge that takes the STABLE_CNT-th identical sample.
    assign dig_onehot = $onehot(dig);
    assign same       = (dig == dig_q) && (seg == seg_q);

    always_comb begin
        dec_nib   = 4'hF;
        dec_blank = 1'b0;
        dec_inv   = 1'b0;
        case (seg[6:0])
            7'h00: begin dec_nib = 4'h0; dec_blank = 1'b1; end
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
`endif
            default: dec_inv = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dig_onehot) begin
                    state_d = S_TRACK;
                    cnt_d   = 4'd1;
                end else begin
                    cnt_d = 4'd0;
                end
            end
            S_TRACK: begin
                if (!dig_onehot) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (same) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == STABLE_W) begin
                        capture = 1'b1;
                        state_d = S_HELD;
                    end
                end else begin
                    cnt_d = 4'd1;
                end
            end
            S_HELD: begin
                if (!dig_onehot) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (!same) begin
                    state_d = S_TRACK;
                    cnt_d   = 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        seg_d      = seg;
        dig_d      = dig;
        wk_bcd_d   = wk_bcd_q;
        wk_dp_d    = wk_dp_q;
        wk_blank_d = wk_blank_q;
        wk_inv_d   = wk_inv_q;
        captured_d = captured_q;
        fbcd_d     = fbcd_q;
        fdp_d      = fdp_q;
        fblank_d   = fblank_q;
        finv_d     = finv_q;
        fv_d       = fv_q & ~frame_ready;
        err_d      = err_q & ~err_clr;
        ovr_d      = ovr_q & ~err_clr;
        if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig[i]) begin
                    wk_bcd_d[4*i +: 4] = dec_nib;
                    wk_dp_d[i]         = seg[7];
                    wk_blank_d[i]      = dec_blank;
                    wk_inv_d[i]        = dec_inv;
                end
            end
            captured_d = captured_q | dig;
            if (dec_inv) err_d = 1'b1;
            if (&captured_d) begin
                captured_d = '0;
                // An unaccepted frame is kept; the newer one is dropped and flagged.
                if (fv_q && !frame_ready) begin
                    ovr_d = 1'b1;
                end else begin
                    fbcd_d   = wk_bcd_d;
                    fdp_d    = wk_dp_d;
                    fblank_d = wk_blank_d;
                    finv_d   = wk_inv_d;
                    fv_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            seg_q      <= '0;
            dig_q      <= '0;
            wk_bcd_q   <= '0;
            wk_dp_q    <= '0;
            wk_blank_q <= '0;
            wk_inv_q   <= '0;
            captured_q <= '0;
            fbcd_q     <= '0;
            fdp_q      <= '0;
            fblank_q   <= '0;
            finv_q     <= '0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
            wk_bcd_q   <= wk_bcd_d;
            wk_dp_q    <= wk_dp_d;
            wk_blank_q <= wk_blank_d;
            wk_inv_q   <= wk_inv_d;
            captured_q <= captured_d;
            fbcd_q     <= fbcd_d;
            fdp_q      <= fdp_d;
            fblank_q   <= fblank_d;
            finv_q     <= finv_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign frame_valid = fv_q;
    assign frame_bcd   = fbcd_q;
    assign frame_dp    = fdp_q;
    assign frame_blank = fblank_q;
    assign frame_inv   = finv_q;
    assign err         = err_q;
    assign overrun     = ovr_q;
endmodule
